// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers and a fixed-latency Busy window.
// Operands are latched at start; HI/LO change only at completion, on mthi/mtlo, or on reset.
//
// state | meaning
// IDLE  | waiting for Start; mthi/mtlo are applied directly from A
// RUN   | operation in flight, cnt counts down to the completion edge
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW      = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   op_a, op_b;
  logic [1:0]    op_code;
  logic          accept, done;
  logic          wr_mthi, wr_mtlo;

  logic [63:0]   prod_s, prod_u;
  logic          sgn, a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start && !MDOp[2]) begin
          accept    = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_nxt = cnt - CW'(1);
        // <= rather than == so a zero-cycle parameter cannot wedge the FSM
        if (cnt <= CW'(1)) begin
          done      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy    = (state == RUN);
  assign wr_mthi = (state == IDLE) && Start && (MDOp == 3'b100);
  assign wr_mtlo = (state == IDLE) && Start && (MDOp == 3'b101);

  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};

  // Sign-magnitude division: 0x80000000 / -1 falls out as 0x80000000 rem 0
  assign sgn   = ~op_code[0];
  assign a_neg = sgn & op_a[31];
  assign b_neg = sgn & op_b[31];
  assign a_mag = a_neg ? (32'd0 - op_a) : op_a;
  assign b_mag = b_neg ? (32'd0 - op_b) : op_b;
  assign b_div = (op_b == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (op_code)
      2'b00: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'b01: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      default: begin
        res_hi = rem;
        res_lo = quo;
        res_wr = (op_b != 32'd0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      op_code <= 2'b00;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_a    <= A;
        op_b    <= B;
        op_code <= MDOp[1:0];
      end
      if (done && res_wr) begin
        HI <= res_hi;
        LO <= res_lo;
      end
      if (wr_mthi) HI <= A;
      if (wr_mtlo) LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: inputs driven on the falling edge,
// outputs sampled on the falling edge, expected values hand-computed.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the first idle cycle
  // so that a following call starts back-to-back.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int cyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7));
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Busy) n++;
      else break;
    end
    chk({tag, "_busy"}, 32'(n), 32'(cyc));
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    reset = 1'b1; Start = 1'b0; MDOp = 3'b000; A = 32'd0; B = 32'd0;
    #2;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op("mult",  3'b000, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
    do_op("div",   3'b010, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu0", 3'b011, 32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divov", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    do_op("divnb", 3'b010, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    do_op("divu",  3'b011, 32'hFFFFFFF9, 32'd16,       10, 32'h00000009, 32'h0FFFFFFF);

    // mthi then mtlo
    Start = 1'b1; MDOp = 3'b100; A = 32'h12345678;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo", LO, 32'h0FFFFFFF);
    chk("mthi_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    Start = 1'b1; MDOp = 3'b101; A = 32'h9ABCDEF0;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_hi", HI, 32'h12345678);
    chk("mtlo_busy", 32'(Busy), 32'd0);

    // reserved opcodes do nothing
    @(negedge clk);
    Start = 1'b1; MDOp = 3'b110; A = 32'h55555555; B = 32'd1;
    @(posedge clk); #1;
    MDOp = 3'b111;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("rsv_busy", 32'(Busy), 32'd0);
    chk("rsv_hi", HI, 32'h12345678);
    chk("rsv_lo", LO, 32'h9ABCDEF0);

    // overlap: Start with mult during div, operands toggling throughout
    @(negedge clk);
    Start = 1'b1; MDOp = 3'b010; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!Busy) break;
      n++;
      if (n == 5) chk("ovl_hold_lo", LO, 32'h9ABCDEF0);
      Start = (n == 3);
      MDOp = 3'b000;
      A = $urandom; B = $urandom;
    end
    Start = 1'b0;
    chk("ovl_busy", 32'(n), 32'd10);
    chk("ovl_hi", HI, 32'd2);
    chk("ovl_lo", LO, 32'd14);
    @(negedge clk);
    chk("ovl_no_restart", 32'(Busy), 32'd0);

    // reset mid-operation
    Start = 1'b1; MDOp = 3'b000; A = 32'd5; B = 32'd6;
    @(posedge clk); #1;
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_pre_busy", 32'(Busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rmid_busy", 32'(Busy), 32'd0);
    chk("rmid_hi", HI, 32'd0);
    chk("rmid_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op("fresh", 3'b000, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL provide the parameter MULT_CYCLES, default 5, the number of cycles Busy stays high for mult/multu.
REQ-002 The block SHALL provide the parameter DIV_CYCLES, default 10, the number of cycles Busy stays high for div/divu.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have the port Start, input, 1 bit: one-cycle strobe, driven high while an MDU instruction sits in E.
REQ-006 The block SHALL have the port MDOp, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are reserved.
REQ-007 The block SHALL have the port A, input, 32 bits: forwarded rs operand from E.
REQ-008 The block SHALL have the port B, input, 32 bits: forwarded rt operand from E.
REQ-009 The block SHALL have the port Busy, output, 1 bit: an operation is in flight; feeds the hazard unit stall logic.
REQ-010 The block SHALL have the port HI, output, 32 bits: architectural HI register.
REQ-011 The block SHALL have the port LO, output, 32 bits: architectural LO register.

Function
REQ-012 The block SHALL use two states, IDLE and RUN, with a down-counter cnt of at least 4 bits.
REQ-013 When in IDLE and Start=1 with MDOp in {000..011} at a clock edge, the block SHALL enter RUN, load cnt with MULT_CYCLES or DIV_CYCLES, and latch A, B and MDOp into internal operand registers.
REQ-014 Busy SHALL be 1 exactly while the state is RUN, giving exactly MULT_CYCLES (or DIV_CYCLES) consecutive cycles of Busy=1 starting the cycle after the Start edge.
REQ-015 In RUN the block SHALL decrement cnt on each edge; on the edge where cnt goes 1->0 it SHALL write HI/LO and return to IDLE in the same edge, so the new HI/LO are visible in the first cycle with Busy=0.
REQ-016 mult SHALL produce the signed 64-bit product of the latched operands, split as {HI,LO}.
REQ-017 multu SHALL produce the unsigned 64-bit product, split as {HI,LO}.
REQ-018 div SHALL produce signed LO=quotient and HI=remainder, truncating toward zero, with the remainder taking the sign of the dividend.
REQ-019 divu SHALL produce unsigned LO=quotient and HI=remainder.
REQ-020 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-021 Division by zero (latched B=0) SHALL still run DIV_CYCLES cycles of Busy and SHALL leave HI and LO unchanged.
REQ-022 Results SHALL be computed from the latched operands only; changes on A, B or MDOp during RUN SHALL have no effect.
REQ-023 When in IDLE and Start=1 with MDOp=100 at an edge, the block SHALL set HI<=A at that edge, with no change to Busy.
REQ-024 When in IDLE and Start=1 with MDOp=101 at an edge, the block SHALL set LO<=A at that edge, with no change to Busy.
REQ-025 Start=1 with a reserved MDOp SHALL have no effect.
REQ-026 Start=1 while in RUN SHALL be ignored: no restart, no reload of cnt, no HI/LO write. The hazard unit guarantees this case does not occur, but the block SHALL still be robust to it.
REQ-027 HI and LO SHALL change only at the completion edge of an operation, on an mthi/mtlo edge, or on reset; they SHALL never hold partial results.
REQ-028 A new Start SHALL be accepted in the first IDLE cycle after completion, so back-to-back operations produce no bubble beyond the Busy window.

Reset
REQ-029 While reset=1, the block SHALL immediately force HI=0, LO=0, Busy=0, cnt=0 and state=IDLE, without waiting for a clock edge.
REQ-030 Reset asserted mid-operation SHALL abort the operation and discard its result; after reset is released, the first Start SHALL behave exactly as from power-up.

Verification
REQ-031 The bench SHALL cover mult: Start, MDOp=000, A=0xFFFFFFFE (-2), B=3 -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 The bench SHALL cover multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 Busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 The bench SHALL cover div: A=-7 (0xFFFFFFF9), B=2 -> after 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. It SHALL then cover divu with A=7, B=0 -> 10 Busy cycles, with HI and LO unchanged.
REQ-034 The bench SHALL cover mthi then mtlo: A=0x12345678 with MDOp=100, then A=0x9ABCDEF0 with MDOp=101 -> HI and LO update on the respective edges, and Busy stays 0 throughout.
REQ-035 The bench SHALL cover overlap: start div, pulse Start with mult at Busy cycle 3, and toggle A and B during RUN -> Busy still falls after 10 cycles, and the div result matches the originally latched operands.
REQ-036 The bench SHALL cover reset mid-operation: assert reset at Busy cycle 2 of a mult -> Busy=0 and HI=LO=0 asynchronously; then a fresh mult 3x4 -> LO=12, HI=0 after 5 cycles.
